// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_transmitter.
// Optional per-requester lock keeps multi-byte frames together.
//
// Ports:
//   clk, l_ready_reset        clock, async active-high reset
//   req, lock, req_data       per-requester request/lock/byte
//   ack                       one-cycle pulse, byte latched
//   done                      one-cycle pulse, byte finished
//   grant_id                  owner of current/last byte
//   tx_data, tx_send, tx_busy transmitter handshake
//   active                    state is not IDLE
//   err_timeout               sticky, tx never went busy
//   sent_count                completed bytes, wrapping
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4096,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 l_ready_reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   lock,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 done,
  output logic [2:0]           grant_id,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 active,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     sent_count
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [TW-1:0] tcnt;

  logic       hold;
  logic [2:0] rr_win;
  logic [2:0] win;
  logic [2:0] nxt_ptr;
  logic [7:0] win_data;
  int         best;

  // Lock holder keeps the grant; otherwise the
  // requester closest to ptr (upward, wrapping) wins.
  always_comb begin
    hold   = 1'b0;
    rr_win = grant_id;
    best   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i) && req[i] && lock[i])
        hold = 1'b1;
      if (req[i] &&
          ((i + NUM_REQ - int'(ptr)) % NUM_REQ) < best) begin
        best   = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
        rr_win = 3'(i);
      end
    end
    win      = hold ? grant_id : rr_win;
    nxt_ptr  = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
    win_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == 3'(i))
        win_data = req_data[8*i +: 8];
  end

  always_ff @(posedge clk or posedge l_ready_reset) begin
    if (l_ready_reset) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      tcnt        <= '0;
      ack         <= '0;
      done        <= 1'b0;
      grant_id    <= 3'd0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
      sent_count  <= '0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            tx_data  <= win_data;
            grant_id <= win;
            ptr      <= nxt_ptr;
            ack      <= NUM_REQ'(1) << win;
            tcnt     <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state      <= IDLE;
            done       <= 1'b1;
            sent_count <= sent_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_send = (state == SEND);
  assign active  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench for uart_tx_arbiter.
// Behavioural arbiter model and transmitter model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BT = 24;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           done;
  logic [2:0]     grant_id;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           active;
  logic           err_timeout;
  logic [CW-1:0]  sent_count;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .BUSY_TIMEOUT(BT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .l_ready_reset(rst),
    .req(req),
    .lock(lock),
    .req_data(req_data),
    .ack(ack),
    .done(done),
    .grant_id(grant_id),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .active(active),
    .err_timeout(err_timeout),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // transmitter model
  int   ph = 0;
  int   dly = 0;
  int   hold_c = 0;
  logic mb = 1'b0;
  logic spur = 1'b0;
  logic dead = 1'b0;

  assign tx_busy = mb | spur;

  always @(negedge clk) begin
    if (rst) begin
      ph = 0;
      mb = 1'b0;
    end else begin
      case (ph)
        0: if (tx_send && !dead) begin
          dly = $urandom_range(1, 20);
          ph  = 1;
        end
        1: begin
          dly--;
          if (dly == 0) begin
            mb     = 1'b1;
            hold_c = $urandom_range(1, 30);
            ph     = 2;
          end
        end
        2: begin
          hold_c--;
          if (hold_c == 0) begin
            mb = 1'b0;
            ph = 0;
          end
        end
        default: ph = 0;
      endcase
    end
  end

  // requesters and reference model
  int         rem[N];
  logic [7:0] cur[N];
  int         m_ptr = 0;
  int         m_prev = 0;
  int         m_cnt = 0;
  bit         inflight = 0;
  int         acks = 0;
  int         dones = 0;
  int         lock_mode = 0;
  int         n1 = 0;
  bit         hold_req = 0;
  int         gq[$];

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req[i]          = (rem[i] > 0);
      req_data[8*i+:8] = cur[i];
    end
  endtask

  function automatic int pick();
    if (req[m_prev] && lock[m_prev]) return m_prev;
    for (int k = 0; k < N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++)
      if (rem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    int w;
    @(negedge clk);
    if (ack != '0) begin
      w = pick();
      chk("ack_onehot", $countones(ack), 1);
      chk("ack_overlap", 32'(inflight), 0);
      if (w < 0) begin
        chk("ack_spurious", 32'(ack), 0);
      end else begin
        chk("ack_id", 32'(ack), 32'(1) << w);
        chk("grant_id", 32'(grant_id), w);
        chk("tx_data", 32'(tx_data), 32'(cur[w]));
        m_prev = w;
        m_ptr  = (w + 1) % N;
        gq.push_back(w);
        if (w == 1) n1++;
        if (!hold_req) begin
          rem[w]--;
          cur[w] = 8'($urandom);
        end
      end
      inflight = 1'b1;
      acks++;
    end
    if (done) begin
      chk("done_expected", 32'(inflight), 1);
      inflight = 1'b0;
      m_cnt++;
      dones++;
      chk("sent_count", 32'(sent_count), m_cnt % (1 << CW));
    end
    if (lock_mode == 1) begin
      lock    = '0;
      lock[1] = (n1 >= 1 && n1 < 3);
    end else if (lock_mode == 2) begin
      if ($urandom_range(0, 7) == 0) lock = N'($urandom);
    end
    apply();
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_prev   = 0;
    m_cnt    = 0;
    inflight = 1'b0;
    n1       = 0;
    gq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 0;
    lock      = '0;
    lock_mode = 0;
    hold_req  = 1'b0;
    dead      = 1'b0;
    apply();
    step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_send", 32'(tx_send), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_cnt", 32'(sent_count), 0);
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_until_idle(int limit);
    int lim = 0;
    do begin
      step();
      lim++;
    end while ((pending() || inflight || active) && lim < limit);
    chk("run_drain",
        32'(pending() || inflight || active), 0);
  endtask

  int exp_rr[6] = '{0, 1, 3, 0, 1, 3};
  int exp_lk[6] = '{0, 1, 1, 1, 0, 1};

  initial begin
    int a0;
    int d0;
    int n;
    int lim;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cur[i] = 8'($urandom);
    end
    lock = '0;
    apply();

    // single byte from requester 2
    do_reset();
    rem[2] = 1;
    cur[2] = 8'h5A;
    apply();
    run_until_idle(500);
    chk("sb_acks", gq.size(), 1);
    chk("sb_gid", 32'(grant_id), 2);
    chk("sb_cnt", 32'(sent_count), 1);

    // spurious busy while idle is ignored
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("spur_idle", 32'(active), 0);
    end
    spur = 1'b0;
    step();

    // round-robin over 0,1,3
    do_reset();
    rem[0] = 2;
    rem[1] = 2;
    rem[3] = 2;
    apply();
    run_until_idle(2000);
    chk("rr_n", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk("rr_order", gq[k], exp_rr[k]);

    // lock frame on requester 1
    do_reset();
    lock_mode = 1;
    rem[0] = 2;
    rem[1] = 4;
    apply();
    run_until_idle(2000);
    chk("lk_n", gq.size(), 6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      chk("lk_order", gq[k], exp_lk[k]);

    // start timeout, twice
    do_reset();
    dead     = 1'b1;
    hold_req = 1'b1;
    rem[0]   = 1;
    apply();
    d0 = dones;
    for (int r = 0; r < 2; r++) begin
      a0  = acks;
      lim = 0;
      while (acks == a0 && lim < 100) begin
        step();
        lim++;
      end
      chk("to_ack", acks, a0 + 1);
      n = 0;
      while (tx_send && n < 200) begin
        n++;
        step();
      end
      chk("to_cycles", n, BT);
      chk("to_err", 32'(err_timeout), 1);
      chk("to_active", 32'(active), 0);
      chk("to_cnt", 32'(sent_count), 0);
      inflight = 1'b0;
    end
    chk("to_no_done", dones - d0, 0);

    // reset in the middle of a byte
    do_reset();
    rem[0] = 1;
    rem[2] = 1;
    apply();
    lim = 0;
    while (!(active && !tx_send && tx_busy) && lim < 200) begin
      step();
      lim++;
    end
    chk("mr_reach", 32'(active && !tx_send), 1);
    rst = 1'b1;
    #1;
    chk("mr_send", 32'(tx_send), 0);
    chk("mr_active", 32'(active), 0);
    chk("mr_cnt", 32'(sent_count), 0);
    chk("mr_gid", 32'(grant_id), 0);
    model_reset();
    rem[0] = 1;
    apply();
    step();
    step();
    rst = 1'b0;
    run_until_idle(1000);
    chk("mr_first", gq.size() > 0 ? gq[0] : 99, 0);
    chk("mr_n", gq.size(), 2);
    chk("mr_cnt2", 32'(sent_count), 2);

    // random traffic, 17 bytes, counter wraps
    do_reset();
    lock_mode = 2;
    for (int k = 0; k < 17; k++)
      rem[$urandom_range(0, N - 1)]++;
    for (int i = 0; i < N; i++) cur[i] = 8'($urandom);
    apply();
    d0 = dones;
    run_until_idle(8000);
    chk("wrap_dones", dones - d0, 17);
    chk("wrap_cnt", 32'(sent_count), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
